// File: rtl/ov_video_tx_if.sv
// rtl/ov_video_tx_if.sv - pixel source stream and DCMI video bus between ov_video_tx and its peers
//
// Signals:
//   pix_data/pix_valid  source -> transmitter, pixel sample and its valid
//   pix_ready           transmitter -> source, sample consumed this clk when pix_valid=1
//   pclk/vsync/href     transmitter -> sink, DCMI timing
//   vdata               transmitter -> sink, DCMI pixel data
// master is the transmitter side, slave is the source/sink side.
interface ov_video_tx_if #(
    parameter int VDATA_WIDTH = 10
);
    logic [VDATA_WIDTH-1:0] pix_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   pclk;
    logic                   vsync;
    logic                   href;
    logic [VDATA_WIDTH-1:0] vdata;

    modport master (
        input  pix_data, pix_valid,
        output pix_ready, pclk, vsync, href, vdata
    );

    modport slave (
        output pix_data, pix_valid,
        input  pix_ready, pclk, vsync, href, vdata
    );
endinterface

// File: rtl/ov_video_tx.sv
// rtl/ov_video_tx.sv - OV7725-style DCMI camera-side transmitter / sensor emulator
//
// Ports:
//   clk          system clock; pclk is generated as clk/2
//   rstn         asynchronous active-low reset
//   enable       start/continue frame generation (checked at frame boundaries)
//   pattern_sel  1 = internal ramp pattern, 0 = pixel stream; latched at frame start
//   bus          ov_video_tx_if.master: pix_data/pix_valid/pix_ready, pclk/vsync/href/vdata
//   frame_done   one-clk pulse on the last tick of each frame
//   underflow    one-clk pulse when an active pixel slot found no valid input
module ov_video_tx #(
    parameter int VDATA_WIDTH = 10,
    parameter int PIXEL_NUM   = 320,
    parameter int ROW_NUM     = 240,
    parameter int HBLANK      = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enable,
    input  logic         pattern_sel,
    ov_video_tx_if.master bus,
    output logic         frame_done,
    output logic         underflow
);
    localparam int LINE_LEN = PIXEL_NUM + HBLANK;
    localparam int V_MAX_A  = (ROW_NUM > VBP_LINES) ? ROW_NUM : VBP_LINES;
    localparam int V_MAX_B  = (VFP_LINES > VSYNC_LINES) ? VFP_LINES : VSYNC_LINES;
    localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int H_W      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int V_W      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

    state_t           state, st_n;
    logic [H_W-1:0]   h_cnt, h_n;
    logic [V_W-1:0]   v_cnt, v_n;
    logic             pclk_r;
    logic             tick;
    logic             frame_start, frame_end;
    logic             pat_r, pat_eff;
    logic             href_n, take_pix;
    logic [VDATA_WIDTH-1:0] vdata_n;

    function automatic int lines_of(input state_t s);
        int n;
        case (s)
            S_VSYNC:  n = VSYNC_LINES;
            S_VBP:    n = VBP_LINES;
            S_ACTIVE: n = ROW_NUM;
            S_VFP:    n = VFP_LINES;
            default:  n = 0;
        endcase
        return n;
    endfunction

    // Next non-empty state of the frame sequence; S_IDLE here means "frame over".
    // Called with S_IDLE it yields the first state of a frame.
    function automatic state_t chain_after(input state_t s);
        state_t r;
        r = S_IDLE;
        if (s == S_IDLE && VSYNC_LINES > 0)
            r = S_VSYNC;
        else if ((s == S_IDLE || s == S_VSYNC) && VBP_LINES > 0)
            r = S_VBP;
        else if ((s == S_IDLE || s == S_VSYNC || s == S_VBP) && ROW_NUM > 0)
            r = S_ACTIVE;
        else if (s != S_VFP && VFP_LINES > 0)
            r = S_VFP;
        return r;
    endfunction

    // The tick is the clk whose edge takes pclk 1->0; everything the sink sees
    // changes there, so it is stable across the following pclk rising edge.
    assign tick = pclk_r;

    // Counters describe the pixel slot currently on the bus. The _n values are
    // the slot presented after the coming tick, and outputs are registered from
    // them so they line up with the counters.
    always_comb begin
        st_n        = state;
        h_n         = h_cnt;
        v_n         = v_cnt;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        if (state == S_IDLE) begin
            if (enable) begin
                st_n        = chain_after(S_IDLE);
                h_n         = '0;
                v_n         = '0;
                frame_start = 1'b1;
            end
        end else if (int'(h_cnt) == LINE_LEN - 1) begin
            h_n = '0;
            if (int'(v_cnt) == lines_of(state) - 1) begin
                v_n = '0;
                if (chain_after(state) == S_IDLE) begin
                    frame_end = 1'b1;
                    if (enable) begin
                        st_n        = chain_after(S_IDLE);
                        frame_start = 1'b1;
                    end else begin
                        st_n = S_IDLE;
                    end
                end else begin
                    st_n = chain_after(state);
                end
            end else begin
                v_n = v_cnt + V_W'(1);
            end
        end else begin
            h_n = h_cnt + H_W'(1);
        end
    end

    // pattern_sel is live only in the tick that starts a frame; otherwise the
    // latched copy rules the whole frame.
    assign pat_eff  = frame_start ? pattern_sel : pat_r;
    assign href_n   = (st_n == S_ACTIVE) && (int'(h_n) < PIXEL_NUM);
    assign take_pix = tick && href_n && !pat_eff;

    always_comb begin
        vdata_n = '0;
        if (href_n) begin
            if (pat_eff)
                vdata_n = VDATA_WIDTH'(int'(h_n) + int'(v_n));
            else if (bus.pix_valid)
                vdata_n = bus.pix_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            pat_r <= 1'b0;
        end else if (tick) begin
            state <= st_n;
            h_cnt <= h_n;
            v_cnt <= v_n;
            if (frame_start)
                pat_r <= pattern_sel;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pclk_r    <= 1'b0;
            bus.vsync <= 1'b0;
            bus.href  <= 1'b0;
            bus.vdata <= '0;
        end else begin
            pclk_r <= ~pclk_r;
            if (tick) begin
                bus.vsync <= (st_n == S_VSYNC);
                bus.href  <= href_n;
                bus.vdata <= vdata_n;
            end
        end
    end

    // Handshake and pulses decode registered state, so reset clears them at once.
    assign bus.pclk      = pclk_r;
    assign bus.pix_ready = take_pix;
    assign underflow     = take_pix && !bus.pix_valid;
    assign frame_done    = tick && frame_end;
endmodule

// File: tb/tb_ov_video_tx.sv
// tb/tb_ov_video_tx.sv - self-checking bench for ov_video_tx with a small frame geometry
module tb_ov_video_tx;
    localparam int VW = 10;
    localparam int PN = 4;
    localparam int RN = 2;
    localparam int HB = 2;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LL = PN + HB;
    localparam int FL = (VS + VB + RN + VF) * LL * 2;  // clk per frame
    localparam int NF = 9;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enable = 1'b0;
    logic pattern_sel = 1'b0;
    logic frame_done;
    logic underflow;

    ov_video_tx_if #(.VDATA_WIDTH(VW)) bus();

    ov_video_tx #(
        .VDATA_WIDTH(VW), .PIXEL_NUM(PN), .ROW_NUM(RN), .HBLANK(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VB), .VFP_LINES(VF)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .bus(bus.master),
        .frame_done(frame_done),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // mode: 0 = source always valid 0x3A0.., 1 = invalid at row0 pixel2, 2 = random
    typedef struct {
        bit pat;
        int mode;
        bit drop_en;
        int rst_at;
        int exp_rdy;
        int exp_uf;   // -1: taken from the reference model
    } frame_cfg_t;

    frame_cfg_t tbl[NF];
    int passed = 0;
    int total  = 0;
    int cur_n  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cur_n, act, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pclk"}, bus.pclk, 0);
        chk({tag, "_vsync"}, bus.vsync, 0);
        chk({tag, "_href"}, bus.href, 0);
        chk({tag, "_vdata"}, bus.vdata, 0);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    // Leaves the bench inside the tick clk that launches a frame, so the next
    // negedge is frame cycle 0.
    task automatic sync_start(input bit pat);
        bit found = 1'b0;
        for (int j = 0; j < 6 && !found; j++) begin
            @(negedge clk);
            enable = 1'b1;
            pattern_sel = pat;
            bus.pix_valid = 1'b0;
            #1;
            if (bus.pclk) found = 1'b1;
        end
        chk("sync_tick_found", found, 1);
        chk("sync_vsync_low", bus.vsync, 0);
    endtask

    task automatic release_reset(input bit pat);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("release_pclk_low", bus.pclk, 0);
        sync_start(pat);
    endtask

    task automatic idle_check(input int cycles);
        for (int m = 0; m < cycles; m++) begin
            cur_n = m;
            @(negedge clk);
            pattern_sel = 1'($urandom_range(0, 1));
            bus.pix_valid = 1'b1;
            #1;
            chk("idle_pclk", bus.pclk, m % 2);
            chk("idle_vsync", bus.vsync, 0);
            chk("idle_href", bus.href, 0);
            chk("idle_vdata", bus.vdata, 0);
            chk("idle_pix_ready", bus.pix_ready, 0);
            chk("idle_frame_done", frame_done, 0);
        end
    endtask

    // Reference: frame cycle n shows slot k=n/2; slot k lies on line k/LL at
    // column k%LL. Odd cycles are ticks that launch slot (n+1)/2.
    task automatic run_frame(input frame_cfg_t c, input bit next_pat);
        int held = 0;
        int src_idx = 0;
        int rdy_cnt = 0;
        int uf_cnt = 0;
        int exp_uf = 0;
        int got[$];
        for (int n = 0; n < FL; n++) begin
            int k, line, h, r, nk, nh, nr, data, want;
            bit href_e, nhref, pr_e, uf_e, valid;
            cur_n = n;
            @(negedge clk);
            pattern_sel = (n == FL - 1) ? next_pat : 1'($urandom_range(0, 1));
            enable = !(c.drop_en && n >= 30);
            nk = ((n + 1) / 2) % (FL / 2);
            nh = nk % LL;
            nr = nk / LL - VS - VB;
            nhref = (n % 2 == 1) && nr >= 0 && nr < RN && nh < PN;
            case (c.mode)
                0: begin valid = 1'b1; data = 'h3A0 + src_idx; end
                1: begin valid = !(nhref && nr * PN + nh == 2); data = 'h3A0 + src_idx; end
                default: begin valid = ($urandom_range(0, 3) != 0); data = int'($urandom_range(0, 1023)); end
            endcase
            bus.pix_valid = valid;
            bus.pix_data = VW'(data);
            #1;
            k = n / 2;
            line = k / LL;
            h = k % LL;
            r = line - VS - VB;
            href_e = r >= 0 && r < RN && h < PN;
            pr_e = nhref && !c.pat;
            uf_e = pr_e && !valid;
            chk("pclk", bus.pclk, n % 2);
            chk("vsync", bus.vsync, line < VS);
            chk("href", bus.href, href_e);
            chk("vdata", bus.vdata, held);
            chk("pix_ready", bus.pix_ready, pr_e);
            chk("underflow", underflow, uf_e);
            chk("frame_done", frame_done, n == FL - 1);
            if (bus.pix_ready) rdy_cnt++;
            if (underflow) uf_cnt++;
            if (uf_e) exp_uf++;
            if (n % 2 == 1 && href_e) got.push_back(int'(bus.vdata));
            if (n == c.rst_at) begin
                rstn = 1'b0;
                #1;
                chk_reset_vals("midreset");
                return;
            end
            if (n % 2 == 1) begin
                if (!nhref) want = 0;
                else if (c.pat) want = (nh + nr) % 1024;
                else want = valid ? data : 0;
                held = want;
            end
            if (pr_e && valid) src_idx++;
        end
        chk("ready_count", rdy_cnt, c.exp_rdy);
        chk("underflow_count", uf_cnt, (c.exp_uf < 0) ? exp_uf : c.exp_uf);
        if (!c.pat && c.mode < 2) begin
            chk("seq_len", got.size(), PN * RN);
            for (int i = 0; i < got.size() && i < PN * RN; i++) begin
                int w;
                if (c.mode == 0) w = 'h3A0 + i;
                else if (i == 2) w = 0;
                else w = 'h3A0 + i - ((i > 2) ? 1 : 0);
                chk("seq_vdata", got[i], w);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cur_n);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{pat: 1'b1, mode: 0, drop_en: 1'b0, rst_at: -1, exp_rdy: 0, exp_uf: 0};
        tbl[1] = '{pat: 1'b0, mode: 0, drop_en: 1'b0, rst_at: -1, exp_rdy: 8, exp_uf: 0};
        tbl[2] = '{pat: 1'b0, mode: 1, drop_en: 1'b0, rst_at: -1, exp_rdy: 8, exp_uf: 1};
        tbl[3] = '{pat: 1'b0, mode: 2, drop_en: 1'b0, rst_at: -1, exp_rdy: 8, exp_uf: -1};
        tbl[4] = '{pat: 1'b1, mode: 2, drop_en: 1'b0, rst_at: -1, exp_rdy: 0, exp_uf: 0};
        tbl[5] = '{pat: 1'b0, mode: 2, drop_en: 1'b1, rst_at: -1, exp_rdy: 8, exp_uf: -1};
        tbl[6] = '{pat: 1'b1, mode: 0, drop_en: 1'b0, rst_at: 27, exp_rdy: 0, exp_uf: 0};
        tbl[7] = '{pat: 1'b0, mode: 0, drop_en: 1'b0, rst_at: -1, exp_rdy: 8, exp_uf: 0};
        tbl[8] = '{pat: 1'b1, mode: 0, drop_en: 1'b0, rst_at: -1, exp_rdy: 0, exp_uf: 0};

        rstn = 1'b0;
        enable = 1'b1;
        pattern_sel = tbl[0].pat;
        bus.pix_valid = 1'b0;
        bus.pix_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        release_reset(tbl[0].pat);

        for (int i = 0; i < NF; i++) begin
            bit nxt;
            nxt = (i < NF - 1) ? tbl[i + 1].pat : 1'b1;
            run_frame(tbl[i], nxt);
            if (tbl[i].drop_en) begin
                idle_check(24);
                sync_start(nxt);
            end
            if (tbl[i].rst_at >= 0) begin
                repeat (2) @(negedge clk);
                #1;
                chk_reset_vals("held_reset");
                release_reset(nxt);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
